// File: rtl/intr_ctrl.sv
// Two-source interrupt controller: edge/level capture, priority
// arbitration with one level of nesting, and registered vector strobes.
module intr_ctrl #(
  parameter bit PRIO1_HIGH = 1'b1,
  parameter bit EDGE_TRIG  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq1,
  input  logic       irq2,
  input  logic [1:0] mask,
  input  logic       ei,
  input  logic       di,
  input  logic       reti,
  input  logic       hold,
  output logic       s_intr1,
  output logic       s_intr2,
  output logic [1:0] pending,
  output logic [1:0] in_service,
  output logic [1:0] overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SVC1 = 2'd1,
    SVC2 = 2'd2
  } state_t;

  localparam int HI = PRIO1_HIGH ? 0 : 1;
  localparam int LO = 1 - HI;

  state_t     state;
  logic       ie;
  logic       ok;
  logic [1:0] irq;
  logic [1:0] irq_q;
  logic [1:0] rise;
  logic [1:0] pend_r;
  logic [1:0] elig;
  logic [1:0] take;
  logic [1:0] ret_clr;

  assign irq  = {irq2, irq1};
  assign rise = irq & ~irq_q;

  // Level mode re-requests as soon as the handler retires.
  assign pending = EDGE_TRIG ? pend_r : (irq & ~in_service);

  always_comb begin
    ok = ie & ~hold & ~reti & (state != SVC2);
    elig = 2'b00;
    elig[HI] = pending[HI] & mask[HI] & ok
             & ~in_service[HI];
    elig[LO] = pending[LO] & mask[LO] & ok
             & (in_service == 2'b00);
    take = elig;
    if (elig[HI]) take[LO] = 1'b0;
    ret_clr = 2'b00;
    if (reti && state != IDLE) begin
      if (in_service[HI]) ret_clr[HI] = 1'b1;
      else                ret_clr[LO] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ie         <= 1'b0;
      irq_q      <= 2'b00;
      pend_r     <= 2'b00;
      in_service <= 2'b00;
      overrun    <= 2'b00;
      s_intr1    <= 1'b0;
      s_intr2    <= 1'b0;
    end else begin
      irq_q <= irq;
      if (di)      ie <= 1'b0;
      else if (ei) ie <= 1'b1;
      if (EDGE_TRIG) begin
        pend_r  <= (pend_r & ~take) | rise;
        overrun <= overrun | (rise & pend_r & ~take);
      end else begin
        pend_r  <= 2'b00;
        overrun <= 2'b00;
      end
      in_service <= (in_service & ~ret_clr) | take;
      s_intr1    <= take[0];
      s_intr2    <= take[1];
      unique case (state)
        IDLE: if (|take) state <= SVC1;
        SVC1: begin
          if (|take)     state <= SVC2;
          else if (reti) state <= IDLE;
        end
        SVC2: if (reti) state <= SVC1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
